// File: rtl/piezo_seq_recorder.sv
// Multi-slot key recorder/player for a single piezo line.
// The live key tone and the playback tone are ORed onto the registered piezo output.

module piezo_seq_tone #(
    parameter int CW      = 4,
    parameter int HW      = 8,
    parameter int HP_BASE = 200,
    parameter int HP_STEP = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] code,
    output logic          tone
);
    logic [CW-1:0] code_q;
    logic [HW-1:0] cnt;

    // Reload value is HP-1; the output flips when the down-counter reaches zero.
    function automatic logic [HW-1:0] hp_m1(input logic [CW-1:0] c);
        int hp;
        hp = HP_BASE - (int'(c) - 1) * HP_STEP;
        return HW'(hp - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            code_q <= '0;
            cnt    <= '0;
            tone   <= 1'b0;
        end else begin
            code_q <= code;
            if (code == '0) begin
                cnt  <= '0;
                tone <= 1'b0;
            end else if (code != code_q) begin
                cnt  <= hp_m1(code);
                tone <= 1'b0;
            end else if (cnt == '0) begin
                cnt  <= hp_m1(code);
                tone <= ~tone;
            end else begin
                cnt <= cnt - HW'(1);
            end
        end
    end
endmodule

// state  | meaning
// S_IDLE | waiting for start; live keys still drive the piezo
// S_REC  | sampling key code into the selected slot once per step
// S_PLAY | replaying the selected slot, one entry per step
module piezo_seq_recorder #(
    parameter int KEYS     = 8,
    parameter int SLOTS    = 2,
    parameter int DEPTH    = 16,
    parameter int STEP_CYC = 1000,
    parameter int HP_BASE  = 200,
    parameter int HP_STEP  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [KEYS-1:0]                      keys,
    input  logic                                 rw,
    input  logic [(SLOTS > 1 ? $clog2(SLOTS) : 1)-1:0] slot_sel,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic                                 loop,
    output logic                                 piezo,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 rec_full
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(KEYS + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(STEP_CYC);
    localparam int HW = $clog2(HP_BASE);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] slot_q;
    logic [PW-1:0] ptr;
    logic [TW-1:0] step_cnt;
    logic [LW-1:0] len [SLOTS];
    logic [CW-1:0] mem [SLOTS][DEPTH];

    logic          done_evt, step_tc, last_entry, rec_last, mem_we;
    logic [CW-1:0] live_code, play_code;
    logic          live_tone, play_tone;

    // Lowest-index key wins; no keys pressed encodes as a rest.
    function automatic logic [CW-1:0] encode(input logic [KEYS-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = KEYS - 1; i >= 0; i--)
            if (k[i]) c = CW'(i + 1);
        return c;
    endfunction

    always_comb begin
        state_nx   = state;
        done_evt   = 1'b0;
        step_tc    = (step_cnt == '0);
        last_entry = ((LW'(ptr) + LW'(1)) == len[slot_q]);
        rec_last   = (len[slot_q] == LW'(DEPTH - 1));
        live_code  = encode(keys);
        play_code  = (state == S_PLAY) ? mem[slot_q][ptr] : '0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    if (rw)
                        state_nx = S_REC;
                    else if (len[slot_sel] == '0)
                        done_evt = 1'b1;
                    else
                        state_nx = S_PLAY;
                end
            end
            S_REC: begin
                if (stop || (step_tc && rec_last)) begin
                    state_nx = S_IDLE;
                    done_evt = 1'b1;
                end
            end
            S_PLAY: begin
                if (stop || (step_tc && last_entry && !loop)) begin
                    state_nx = S_IDLE;
                    done_evt = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        mem_we = rst && (state == S_REC) && !stop && step_tc;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[slot_q][ptr] <= live_code;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            slot_q   <= '0;
            ptr      <= '0;
            step_cnt <= '0;
            for (int i = 0; i < SLOTS; i++) len[i] <= '0;
            piezo    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rec_full <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_evt;
            busy  <= (state != S_IDLE);
            piezo <= live_tone | play_tone;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        slot_q   <= slot_sel;
                        ptr      <= '0;
                        step_cnt <= TW'(STEP_CYC - 1);
                        rec_full <= 1'b0;
                        if (rw) len[slot_sel] <= '0;
                    end
                end
                S_REC: begin
                    if (!stop) begin
                        if (step_tc) begin
                            len[slot_q] <= len[slot_q] + LW'(1);
                            ptr         <= ptr + PW'(1);
                            step_cnt    <= TW'(STEP_CYC - 1);
                            if (rec_last) rec_full <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt - TW'(1);
                        end
                    end
                end
                S_PLAY: begin
                    if (!stop) begin
                        if (step_tc) begin
                            ptr      <= last_entry ? '0 : ptr + PW'(1);
                            step_cnt <= TW'(STEP_CYC - 1);
                        end else begin
                            step_cnt <= step_cnt - TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    piezo_seq_tone #(.CW(CW), .HW(HW), .HP_BASE(HP_BASE), .HP_STEP(HP_STEP)) u_live_tone (
        .clk  (clk),
        .rst  (rst),
        .code (live_code),
        .tone (live_tone)
    );

    piezo_seq_tone #(.CW(CW), .HW(HW), .HP_BASE(HP_BASE), .HP_STEP(HP_STEP)) u_play_tone (
        .clk  (clk),
        .rst  (rst),
        .code (play_code),
        .tone (play_tone)
    );
endmodule

// File: tb/tb_piezo_seq_recorder.sv
// Directed bench for piezo_seq_recorder with small parameters (DEPTH=4, STEP_CYC=4, HP 10/2).
// Outputs are sampled on the falling edge; index k of a capture is the sample after start edge + k.

module tb_piezo_seq_recorder;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keys;
    logic       rw;
    logic [0:0] slot_sel;
    logic       start, stop, loop;
    logic       piezo, busy, done, rec_full;

    int n_checks = 0;
    int n_errors = 0;

    logic p_h [64];
    logic d_h [64];
    logic b_h [64];
    logic r_h [64];
    int   p_cnt, d_cnt, b_cnt;

    always #5 clk = ~clk;

    piezo_seq_recorder #(
        .KEYS(8), .SLOTS(2), .DEPTH(4), .STEP_CYC(4), .HP_BASE(10), .HP_STEP(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keys     (keys),
        .rw       (rw),
        .slot_sel (slot_sel),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .piezo    (piezo),
        .busy     (busy),
        .done     (done),
        .rec_full (rec_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic r, input logic s);
        rw       = r;
        slot_sel = s;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic capture(input int n);
        p_cnt = 0; d_cnt = 0; b_cnt = 0;
        for (int k = 0; k < n; k++) begin
            p_h[k] = piezo; d_h[k] = done; b_h[k] = busy; r_h[k] = rec_full;
            p_cnt += int'(piezo); d_cnt += int'(done); b_cnt += int'(busy);
            tick(1);
        end
    endtask

    // Record with keys held, stop sampled on start edge + hold + 1.
    task automatic rec_steps(input string tag, input logic s, input logic [7:0] k, input int hold);
        keys = k;
        pulse_start(1'b1, s);
        tick(hold);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check({tag, "_done"}, done, 1);
        keys = 8'h00;
        tick(1);
        check({tag, "_idle"}, busy, 0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; keys = 8'h00; rw = 1'b0; slot_sel = 1'b0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick(3);
        check("rst_piezo", piezo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", rec_full, 0);
        rst = 1'b1;
        tick(1);

        // Record slot 1 with key 2 held: three full steps before stop.
        rec_steps("rec_s1", 1'b1, 8'h04, 12);
        check("rec_s1_full", rec_full, 0);
        pulse_start(1'b0, 1'b1);
        capture(20);
        check("ply_s1_pcnt", p_cnt, 6);
        check("ply_s1_p7", p_h[7], 0);
        check("ply_s1_p8", p_h[8], 1);
        check("ply_s1_p13", p_h[13], 1);
        check("ply_s1_p14", p_h[14], 0);
        check("ply_s1_done12", d_h[12], 1);
        check("ply_s1_dcnt", d_cnt, 1);
        check("ply_s1_busy12", b_h[12], 1);
        check("ply_s1_busy13", b_h[13], 0);

        // Reset while playing: everything drops, no done afterwards.
        pulse_start(1'b0, 1'b1);
        tick(9);
        check("t1_pre_piezo", piezo, 1);
        rst = 1'b0;
        tick(1);
        check("t1_rst_piezo", piezo, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_done", done, 0);
        tick(2);
        rst = 1'b1;
        capture(8);
        check("t1_post_dcnt", d_cnt, 0);
        check("t1_post_bcnt", b_cnt, 0);
        check("t1_post_pcnt", p_cnt, 0);
        pulse_start(1'b0, 1'b0);
        check("t1_empty_done", done, 1);
        check("t1_empty_busy", busy, 0);
        tick(1);
        check("t1_empty_done1", done, 0);
        check("t1_empty_busy1", busy, 0);

        // Fill slot 0 to DEPTH; slot 1 must keep its three entries.
        rec_steps("rerec_s1", 1'b1, 8'h04, 12);
        keys = 8'h01;
        pulse_start(1'b1, 1'b0);
        capture(20);
        keys = 8'h00;
        check("full_done16", d_h[16], 1);
        check("full_dcnt", d_cnt, 1);
        check("full_r15", r_h[15], 0);
        check("full_r16", r_h[16], 1);
        check("full_busy16", b_h[16], 1);
        check("full_busy17", b_h[17], 0);
        check("full_hold", rec_full, 1);
        tick(2);
        pulse_start(1'b0, 1'b1);
        check("full_clr", rec_full, 0);
        capture(16);
        check("s1_kept_done12", d_h[12], 1);
        check("s1_kept_dcnt", d_cnt, 1);
        pulse_start(1'b0, 1'b0);
        capture(20);
        check("s0_done16", d_h[16], 1);
        check("s0_p11", p_h[11], 0);
        check("s0_p12", p_h[12], 1);

        // Live tone, code 2 -> half-period 8.
        keys = 8'b1000_0010;
        capture(36);
        check("live_p9", p_h[9], 0);
        check("live_p10", p_h[10], 1);
        check("live_p17", p_h[17], 1);
        check("live_p18", p_h[18], 0);
        check("live_p26", p_h[26], 1);
        check("live_pcnt", p_cnt, 16);
        keys = 8'h00;
        tick(3);
        check("live_off", piezo, 0);

        // Looping playback runs past the end until stopped.
        loop = 1'b1;
        pulse_start(1'b0, 1'b1);
        capture(30);
        check("loop_dcnt", d_cnt, 0);
        check("loop_busy29", b_h[29], 1);
        check("loop_p20", p_h[20], 1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        loop = 1'b0;
        check("loop_stop_done", done, 1);
        tick(1);
        check("loop_stop_done1", done, 0);
        check("loop_stop_busy", busy, 0);
        tick(2);
        check("loop_stop_piezo", piezo, 0);

        rw = 1'b0; slot_sel = 1'b1; start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        capture(4);
        check("ss_bcnt", b_cnt, 0);
        check("ss_dcnt", d_cnt, 0);

        // Start and rw/slot_sel changes during REC are ignored.
        keys = 8'h10;
        pulse_start(1'b1, 1'b0);
        tick(2);
        rw = 1'b0; slot_sel = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("ign_done", done, 1);
        keys = 8'h00;
        tick(1);
        check("ign_idle", busy, 0);
        tick(2);
        pulse_start(1'b0, 1'b0);
        capture(12);
        check("ign_s0_done8", d_h[8], 1);
        check("ign_s0_dcnt", d_cnt, 1);
        pulse_start(1'b0, 1'b1);
        capture(16);
        check("ign_s1_done12", d_h[12], 1);
        check("ign_s1_dcnt", d_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
